lsu_issue_queue: RTL and testbench
==================================

LSU_ISSUE_QUEUE -- requirements
Module: lsu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dispatch_en  input  1  a memory op is presented for enqueue this cycle.
REQ-005 SHALL have port dispatch_entry  input  rs_entry_t  the op; fields used: prs1, prs2, prs1_ready, prs2_ready, mem_read, mem_write.
REQ-006 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-007 SHALL have port cdb_en  input  1  a physical-register result broadcast is valid.
REQ-008 SHALL have port cdb_prd  input  PHYS_REG_BITS  destination tag of the broadcast.
REQ-009 SHALL have port lsu_ready  input  1  the LSU can accept an op this cycle.
REQ-010 SHALL have port issue_en  output  1  registered; drives the LSU issue_en.
REQ-011 SHALL have port issue_entry  output  rs_entry_t  registered; drives the LSU issue_entry.
REQ-012 SHALL have port flush  input  1  mispredict/exception flush.

Function
REQ-013 SHALL be a circular FIFO (head, tail, count) and issue strictly in program order, from the head only.
REQ-014 Head eligibility SHALL be: count>0, src1 ready, and (mem_write=0 or src2 ready); loads ignore src2.
REQ-015 When head is eligible and lsu_ready=1 in cycle N, SHALL set issue_en=1 with issue_entry=head contents in cycle N+1 and advance head; otherwise issue_en=0 in N+1.
REQ-016 issue_en SHALL be high for exactly one cycle per op; the same entry SHALL never issue twice.
REQ-017 dispatch_en with full=1 SHALL be ignored (no write, no pointer change).
REQ-018 Dispatch and issue in the same cycle SHALL leave count unchanged; this SHALL work when full (head frees, but full=1 still blocks that cycle's dispatch).
REQ-019 A CDB broadcast SHALL set prs1_ready/prs2_ready in every valid entry whose tag equals cdb_prd.
REQ-020 If dispatch and a matching CDB broadcast occur in the same cycle, the dispatched entry SHALL be written with the matching ready bit(s) set.
REQ-021 Head and tail SHALL wrap modulo DEPTH; full = (count==DEPTH).
REQ-022 flush=1 SHALL, at the next edge, empty the queue and force issue_en=0; flush takes priority over dispatch, issue and wakeup in that cycle.

Reset
REQ-023 While rst=0 SHALL asynchronously clear head, tail, count, all ready bits, issue_en=0, issue_entry='0, full=0.
REQ-024 Reset mid-operation SHALL discard all entries; no issue_en pulse SHALL occur until after the first post-reset dispatch.

Configuration
REQ-025 Macro LSU_IQ_WAKEUP_BYPASS_EN: when defined, head eligibility SHALL also count a same-cycle CDB match as ready, so an op woken in cycle N issues with issue_en=1 in N+1.
REQ-026 Without LSU_IQ_WAKEUP_BYPASS_EN, eligibility SHALL use stored ready bits only; an op woken in cycle N issues with issue_en=1 no earlier than N+2.

Verification
REQ-027 Ready load (prs1_ready=1, prd=10) dispatched with queue empty and lsu_ready=1 -> issue_en=1, issue_entry.prd=10 two edges after dispatch.
REQ-028 Store with prs2=5 not ready at head; cdb_en=1, cdb_prd=5 in cycle N -> issue_en in N+1 with bypass macro, N+2 without.
REQ-029 Dispatch 8 ready loads with lsu_ready=0 -> full=1; 9th dispatch dropped; raise lsu_ready -> 8 issues in order, prd 20..27, then full=0.
REQ-030 Load A (prs1=3 not ready) then ready load B -> B does not issue before A; cdb_prd=3 -> A issues, then B.
REQ-031 Dispatch in same cycle as cdb_prd matching its prs1 -> entry becomes eligible; issues with no further broadcast.
REQ-032 Three ops queued, flush=1 for one cycle -> issue_en=0 thereafter, full=0; new dispatch issues normally; repeat with rst=0 mid-stream -> same empty state.

Source files
------------

// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: circular FIFO of memory ops that issues from the head once its sources are ready.
// Optional LSU_IQ_WAKEUP_BYPASS_EN lets a same-cycle CDB match make the head eligible.
package lsu_iq_pkg;
  localparam int unsigned PHYS_REG_BITS = 6;

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prd;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic                     mem_read;
    logic                     mem_write;
  } rs_entry_t;
endpackage

module lsu_issue_queue
  import lsu_iq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_en,
  input  rs_entry_t                dispatch_entry,
  output logic                     full,
  input  logic                     cdb_en,
  input  logic [PHYS_REG_BITS-1:0] cdb_prd,
  input  logic                     lsu_ready,
  output logic                     issue_en,
  output rs_entry_t                issue_entry,
  input  logic                     flush
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  rs_entry_t         mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  rs_entry_t         head_entry;
  rs_entry_t         disp_entry;
  logic              eligible;
  logic              push;
  logic              pop;

  assign full = (count == CW'(DEPTH));

  always_comb begin
    head_entry = mem[head];
`ifdef LSU_IQ_WAKEUP_BYPASS_EN
    if (cdb_en && (cdb_prd == head_entry.prs1)) head_entry.prs1_ready = 1'b1;
    if (cdb_en && (cdb_prd == head_entry.prs2)) head_entry.prs2_ready = 1'b1;
`endif
    // loads never wait on src2
    eligible = (count != '0) && head_entry.prs1_ready &&
               (!head_entry.mem_write || head_entry.prs2_ready);
    push = dispatch_en && !full;
    pop  = eligible && lsu_ready;
  end

  // an op dispatched alongside its producer's broadcast must not miss the wakeup
  always_comb begin
    disp_entry = dispatch_entry;
    if (cdb_en && (cdb_prd == dispatch_entry.prs1)) disp_entry.prs1_ready = 1'b1;
    if (cdb_en && (cdb_prd == dispatch_entry.prs2)) disp_entry.prs2_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      issue_en    <= 1'b0;
      issue_entry <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PW'(i)] <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      issue_en <= 1'b0;
    end else begin
      if (cdb_en) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (mem[PW'(i)].prs1 == cdb_prd) mem[PW'(i)].prs1_ready <= 1'b1;
          if (mem[PW'(i)].prs2 == cdb_prd) mem[PW'(i)].prs2_ready <= 1'b1;
        end
      end
      if (push) begin
        mem[tail] <= disp_entry;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head        <= head + PW'(1);
        issue_entry <= head_entry;
      end
      issue_en <= pop;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed self-checking bench for lsu_issue_queue; expectations follow LSU_IQ_WAKEUP_BYPASS_EN if defined.
module tb_lsu_issue_queue;
  import lsu_iq_pkg::*;

`ifdef LSU_IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     dispatch_en = 1'b0;
  rs_entry_t                dispatch_entry = '0;
  logic                     full;
  logic                     cdb_en = 1'b0;
  logic [PHYS_REG_BITS-1:0] cdb_prd = '0;
  logic                     lsu_ready = 1'b0;
  logic                     issue_en;
  rs_entry_t                issue_entry;
  logic                     flush = 1'b0;

  int tests = 0;
  int fails = 0;

  lsu_issue_queue #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_en    (dispatch_en),
    .dispatch_entry (dispatch_entry),
    .full           (full),
    .cdb_en         (cdb_en),
    .cdb_prd        (cdb_prd),
    .lsu_ready      (lsu_ready),
    .issue_en       (issue_en),
    .issue_entry    (issue_entry),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] prd, input logic [5:0] s1, input logic [5:0] s2,
                        input logic r1, input logic r2, input logic wr);
    dispatch_entry.prd        = prd;
    dispatch_entry.prs1       = s1;
    dispatch_entry.prs2       = s2;
    dispatch_entry.prs1_ready = r1;
    dispatch_entry.prs2_ready = r2;
    dispatch_entry.mem_read   = ~wr;
    dispatch_entry.mem_write  = wr;
    dispatch_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests++;
    if (issue_en !== 1'b0 || full !== 1'b0 || issue_entry !== '0) begin
      fails++;
      $display("FAIL reset_state: issue_en=%b full=%b entry=%h, expected 0 0 0", issue_en, full, issue_entry);
    end
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_ready_load();
    lsu_ready = 1'b1;
    set_op(6'd10, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    dispatch_en = 1'b0;
    tests++;
    if (issue_en !== 1'b0) begin
      fails++;
      $display("FAIL ready_load_early: issue_en=%b expected 0", issue_en);
    end
    tick();
    tests++;
    if (issue_en !== 1'b1 || issue_entry.prd !== 6'd10) begin
      fails++;
      $display("FAIL ready_load_issue: issue_en=%b prd=%0d expected 1 10", issue_en, issue_entry.prd);
    end
    tick();
    tests++;
    if (issue_en !== 1'b0) begin
      fails++;
      $display("FAIL ready_load_single: issue_en=%b expected 0", issue_en);
    end
  endtask

  task automatic test_store_wakeup();
    lsu_ready = 1'b1;
    set_op(6'd11, 6'd1, 6'd5, 1'b1, 1'b0, 1'b1);
    tick();
    dispatch_en = 1'b0;
    tick();
    tests++;
    if (issue_en !== 1'b0) begin
      fails++;
      $display("FAIL store_wait: issue_en=%b expected 0", issue_en);
    end
    cdb_en = 1'b1;
    cdb_prd = 6'd5;
    tick();
    cdb_en = 1'b0;
    tests++;
    if (issue_en !== BYP) begin
      fails++;
      $display("FAIL store_wake_n1: issue_en=%b expected %b", issue_en, BYP);
    end
    tick();
    tests++;
    if (issue_en !== !BYP) begin
      fails++;
      $display("FAIL store_wake_n2: issue_en=%b expected %b", issue_en, !BYP);
    end
    tick();
    tests++;
    if (issue_en !== 1'b0 || issue_entry.prd !== 6'd11) begin
      fails++;
      $display("FAIL store_done: issue_en=%b prd=%0d expected 0 11", issue_en, issue_entry.prd);
    end
  endtask

  task automatic test_full();
    logic [5:0] exp_prd [9];
    lsu_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_op(6'(20 + i), 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
      tick();
    end
    tests++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL full_set: full=%b expected 1", full);
    end
    set_op(6'd63, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    tests++;
    if (full !== 1'b1 || issue_en !== 1'b0) begin
      fails++;
      $display("FAIL full_drop: full=%b issue_en=%b expected 1 0", full, issue_en);
    end
    // first cycle: full blocks prd 40 while the head issues; next cycle prd 41 enters
    lsu_ready = 1'b1;
    set_op(6'd40, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) exp_prd[i] = 6'(20 + i);
    exp_prd[8] = 6'd41;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) set_op(6'd41, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
      else dispatch_en = 1'b0;
      tests++;
      if (issue_en !== 1'b1 || issue_entry.prd !== exp_prd[i]) begin
        fails++;
        $display("FAIL full_drain[%0d]: issue_en=%b prd=%0d expected 1 %0d", i, issue_en, issue_entry.prd, exp_prd[i]);
      end
      if (i == 0) begin
        tests++;
        if (full !== 1'b0) begin
          fails++;
          $display("FAIL full_clear: full=%b expected 0", full);
        end
      end
    end
    tick();
    tests++;
    if (issue_en !== 1'b0 || full !== 1'b0) begin
      fails++;
      $display("FAIL full_empty: issue_en=%b full=%b expected 0 0", issue_en, full);
    end
  endtask

  task automatic test_order();
    lsu_ready = 1'b1;
    set_op(6'd12, 6'd3, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_op(6'd13, 6'd4, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    dispatch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (issue_en !== 1'b0) begin
        fails++;
        $display("FAIL order_block[%0d]: issue_en=%b expected 0", i, issue_en);
      end
    end
    cdb_en = 1'b1;
    cdb_prd = 6'd3;
    tick();
    cdb_en = 1'b0;
    if (!BYP) tick();
    tests++;
    if (issue_en !== 1'b1 || issue_entry.prd !== 6'd12) begin
      fails++;
      $display("FAIL order_a: issue_en=%b prd=%0d expected 1 12", issue_en, issue_entry.prd);
    end
    tick();
    tests++;
    if (issue_en !== 1'b1 || issue_entry.prd !== 6'd13) begin
      fails++;
      $display("FAIL order_b: issue_en=%b prd=%0d expected 1 13", issue_en, issue_entry.prd);
    end
    tick();
  endtask

  task automatic test_dispatch_wakeup();
    lsu_ready = 1'b1;
    set_op(6'd14, 6'd7, 6'd0, 1'b0, 1'b0, 1'b0);
    cdb_en = 1'b1;
    cdb_prd = 6'd7;
    tick();
    dispatch_en = 1'b0;
    cdb_en = 1'b0;
    tests++;
    if (issue_en !== 1'b0) begin
      fails++;
      $display("FAIL disp_wake_early: issue_en=%b expected 0", issue_en);
    end
    tick();
    tests++;
    if (issue_en !== 1'b1 || issue_entry.prd !== 6'd14) begin
      fails++;
      $display("FAIL disp_wake_issue: issue_en=%b prd=%0d expected 1 14", issue_en, issue_entry.prd);
    end
    tick();
  endtask

  task automatic test_flush_and_reset();
    lsu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(6'(50 + i), 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
      tick();
    end
    dispatch_en = 1'b0;
    lsu_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (issue_en !== 1'b0 || full !== 1'b0) begin
        fails++;
        $display("FAIL flush_empty[%0d]: issue_en=%b full=%b expected 0 0", i, issue_en, full);
      end
      tick();
    end
    set_op(6'd53, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    dispatch_en = 1'b0;
    tick();
    tests++;
    if (issue_en !== 1'b1 || issue_entry.prd !== 6'd53) begin
      fails++;
      $display("FAIL flush_redispatch: issue_en=%b prd=%0d expected 1 53", issue_en, issue_entry.prd);
    end
    for (int i = 0; i < 3; i++) begin
      set_op(6'(60 + i), 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
      tick();
    end
    dispatch_en = 1'b0;
    rst = 1'b0;
    #1;
    tests++;
    if (issue_en !== 1'b0 || full !== 1'b0 || issue_entry !== '0) begin
      fails++;
      $display("FAIL midreset_state: issue_en=%b full=%b entry=%h expected 0 0 0", issue_en, full, issue_entry);
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (issue_en !== 1'b0) begin
        fails++;
        $display("FAIL midreset_quiet[%0d]: issue_en=%b expected 0", i, issue_en);
      end
    end
    set_op(6'd63, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    dispatch_en = 1'b0;
    tick();
    tests++;
    if (issue_en !== 1'b1 || issue_entry.prd !== 6'd63) begin
      fails++;
      $display("FAIL midreset_redispatch: issue_en=%b prd=%0d expected 1 63", issue_en, issue_entry.prd);
    end
  endtask

  initial begin
    test_reset();
    test_ready_load();
    test_store_wakeup();
    test_full();
    test_order();
    test_dispatch_wakeup();
    test_flush_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
